// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl
//
// Sequences an external up-counter through CLEAR / LOAD / RUN commands and
// checks that the counter follows the issued strobes.
//
// Ports
//   clk           : sole clock, all state changes on the rising edge
//   reset         : synchronous, active-high reset
//   cmd_valid     : command offered
//   cmd_ready     : command acceptable (controller idle)
//   cmd_op        : 00 CLEAR, 01 LOAD, 10 RUN, 11 reserved (accepted, no effect)
//   cmd_arg       : LOAD value or RUN cycle count
//   abort         : terminate an active RUN
//   cnt_value     : observed value of the controlled counter
//   cnt_clr       : one-cycle clear strobe to the counter
//   cnt_load      : one-cycle load strobe to the counter
//   cnt_load_val  : load data, valid while cnt_load is high
//   cnt_en        : counter increment enable
//   busy          : controller not idle
//   done          : one-cycle pulse at RUN completion or abort
//   aborted       : last RUN was ended by abort (held until next command)
//   run_remaining : enable cycles still to issue in the current RUN
//   mismatch      : sticky flag, counter diverged from the expected value
// ---------------------------------------------------------------------------
module counter_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_clr,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] run_remaining,
  output logic             mismatch
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0]       OP_CLEAR = 2'b00;
  localparam logic [1:0]       OP_LOAD  = 2'b01;
  localparam logic [1:0]       OP_RUN   = 2'b10;
  localparam logic [WIDTH-1:0] ZERO_C   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C    = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic             cmd_ready_r, busy_r;
  logic             cnt_clr_r, cnt_clr_s;
  logic             cnt_load_r, cnt_load_s;
  logic [WIDTH-1:0] cnt_load_val_r, cnt_load_val_s;
  logic             cnt_en_r, cnt_en_s;
  logic             done_r, done_s;
  logic             aborted_r, aborted_s;
  logic [WIDTH-1:0] run_remaining_r, run_remaining_s;
  logic [WIDTH-1:0] exp_r, exp_s;
  logic             exp_valid_r, exp_valid_s;
  logic             mismatch_r, mismatch_s;
  logic             accept_s;
  logic             clear_accept_s;
  logic             diverged_s;

  assign accept_s       = cmd_valid && (state_r == S_IDLE);
  assign clear_accept_s = accept_s && (cmd_op == OP_CLEAR);

  // Next-state and strobe generation for the command FSM.
  always_comb begin
    state_s         = state_r;
    cnt_clr_s       = 1'b0;
    cnt_load_s      = 1'b0;
    cnt_load_val_s  = cnt_load_val_r;
    cnt_en_s        = 1'b0;
    done_s          = 1'b0;
    aborted_s       = aborted_r;
    run_remaining_s = run_remaining_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          aborted_s = 1'b0;
          case (cmd_op)
            OP_CLEAR: begin
              cnt_clr_s = 1'b1;
            end
            OP_LOAD: begin
              cnt_load_s     = 1'b1;
              cnt_load_val_s = cmd_arg;
            end
            OP_RUN: begin
              if (cmd_arg != ZERO_C) begin
                // The first enable cycle starts right after the accept edge.
                state_s         = S_RUN;
                cnt_en_s        = 1'b1;
                run_remaining_s = cmd_arg;
              end else begin
                state_s         = S_DONE;
                done_s          = 1'b1;
                run_remaining_s = ZERO_C;
              end
            end
            default: begin
              // Reserved opcode: accepted, nothing happens.
              state_s = S_IDLE;
            end
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          // The enable of the cycle ending at this edge still counts;
          // no further enables are issued.
          state_s         = S_DONE;
          done_s          = 1'b1;
          aborted_s       = 1'b1;
          run_remaining_s = ZERO_C;
        end else if (run_remaining_r == ONE_C) begin
          state_s         = S_DONE;
          done_s          = 1'b1;
          run_remaining_s = ZERO_C;
        end else begin
          cnt_en_s        = 1'b1;
          run_remaining_s = run_remaining_r - ONE_C;
        end
      end
      S_DONE: begin
        state_s         = S_IDLE;
        run_remaining_s = ZERO_C;
      end
      default: begin
        state_s         = S_IDLE;
        run_remaining_s = ZERO_C;
      end
    endcase
  end

  // Expected-value tracker follows the strobes exactly as the counter does.
  always_comb begin
    exp_s       = exp_r;
    exp_valid_s = exp_valid_r;
    if (cnt_clr_r) begin
      exp_s       = ZERO_C;
      exp_valid_s = 1'b1;
    end else if (cnt_load_r) begin
      exp_s       = cnt_load_val_r;
      exp_valid_s = 1'b1;
    end else if (cnt_en_r) begin
      exp_s = exp_r + ONE_C;
    end else begin
      exp_s = exp_r;
    end
  end

  // Divergence detection. During the clear strobe cycle both the counter and
  // the tracker are about to be forced to zero, so a stale difference there
  // must not re-arm the flag that the CLEAR just cleared.
  always_comb begin
    diverged_s = exp_valid_r && !cnt_clr_r && (cnt_value != exp_r);
    if (clear_accept_s) begin
      mismatch_s = 1'b0;
    end else if (diverged_s) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = mismatch_r;
    end
  end

  // State and output registers; reset dominates every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= S_IDLE;
      cmd_ready_r     <= 1'b1;
      busy_r          <= 1'b0;
      cnt_clr_r       <= 1'b0;
      cnt_load_r      <= 1'b0;
      cnt_load_val_r  <= ZERO_C;
      cnt_en_r        <= 1'b0;
      done_r          <= 1'b0;
      aborted_r       <= 1'b0;
      run_remaining_r <= ZERO_C;
      exp_r           <= ZERO_C;
      exp_valid_r     <= 1'b0;
      mismatch_r      <= 1'b0;
    end else begin
      state_r         <= state_s;
      cmd_ready_r     <= (state_s == S_IDLE);
      busy_r          <= (state_s != S_IDLE);
      cnt_clr_r       <= cnt_clr_s;
      cnt_load_r      <= cnt_load_s;
      cnt_load_val_r  <= cnt_load_val_s;
      cnt_en_r        <= cnt_en_s;
      done_r          <= done_s;
      aborted_r       <= aborted_s;
      run_remaining_r <= run_remaining_s;
      exp_r           <= exp_s;
      exp_valid_r     <= exp_valid_s;
      mismatch_r      <= mismatch_s;
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign busy          = busy_r;
  assign cnt_clr       = cnt_clr_r;
  assign cnt_load      = cnt_load_r;
  assign cnt_load_val  = cnt_load_val_r;
  assign cnt_en        = cnt_en_r;
  assign done          = done_r;
  assign aborted       = aborted_r;
  assign run_remaining = run_remaining_r;
  assign mismatch      = mismatch_r;

  counter_seq_ctrl_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .cmd_ready (cmd_ready_r),
    .busy      (busy_r),
    .cnt_clr   (cnt_clr_r),
    .cnt_load  (cnt_load_r),
    .cnt_en    (cnt_en_r),
    .done      (done_r)
  );

endmodule

// ---------------------------------------------------------------------------
// counter_seq_ctrl_chk
//
// Structural invariants of the controller outputs.
//
// Ports
//   clk, reset                    : clock and synchronous reset of the parent
//   cmd_ready, busy               : handshake / activity outputs
//   cnt_clr, cnt_load, cnt_en     : counter strobes
//   done                          : completion pulse
// ---------------------------------------------------------------------------
module counter_seq_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic cmd_ready,
  input logic busy,
  input logic cnt_clr,
  input logic cnt_load,
  input logic cnt_en,
  input logic done
);

  a_strobes_exclusive : assert property (
    @(posedge clk) disable iff (reset) $onehot0({cnt_clr, cnt_load, cnt_en}));

  a_ready_is_not_busy : assert property (
    @(posedge clk) disable iff (reset) (cmd_ready == !busy));

  a_done_without_enable : assert property (
    @(posedge clk) disable iff (reset) (done |-> !cnt_en));

  a_done_single_cycle : assert property (
    @(posedge clk) disable iff (reset) (done |=> !done));

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Testbench for counter_seq_ctrl: an ideal external counter (with an optional
// one-shot stall) is driven by the DUT strobes; scenario tasks check the
// sequencing against arithmetic expectations.
module tb_counter_seq_ctrl;
  localparam int W = 8;
  localparam logic [1:0] OP_CLEAR = 2'b00, OP_LOAD = 2'b01, OP_RUN = 2'b10, OP_RSV = 2'b11;

  logic         clk = 1'b0;
  logic         reset, cmd_valid, abort;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_arg;
  logic [W-1:0] cnt_value = 8'hA5;
  logic         cnt_clr, cnt_load, cnt_en, busy, done, aborted, mismatch;
  logic [W-1:0] cnt_load_val, run_remaining;

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;
  int stall_at = -1;

  counter_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .cnt_value(cnt_value),
    .cnt_clr(cnt_clr), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .cnt_en(cnt_en), .busy(busy), .done(done), .aborted(aborted),
    .run_remaining(run_remaining), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // External counter; skips exactly one increment when en_count hits stall_at.
  always @(posedge clk) begin
    if (cnt_clr) cnt_value <= '0;
    else if (cnt_load) cnt_value <= cnt_load_val;
    else if (cnt_en) begin
      en_count <= en_count + 1;
      if (en_count != stall_at) cnt_value <= cnt_value + 8'd1;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one command and observe until cmd_ready returns, then idle one cycle.
  // abort_at = k > 0 raises abort during the k-th enable cycle.
  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] arg, input int abort_at,
                        output int n_en, output int n_done, output int n_cyc, output int n_busy,
                        output int n_strobe, output int n_bad, output logic ab_seen, output logic to);
    n_en = 0; n_done = 0; n_cyc = 0; n_busy = 0; n_strobe = 0; n_bad = 0; ab_seen = 1'b0; to = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    step();
    cmd_valid = 1'b0; cmd_arg = W'($urandom);
    for (int c = 0; c < 1000; c++) begin
      n_cyc++;
      abort = 1'b0;
      if (cnt_en) begin
        if (int'(run_remaining) != int'(arg) - n_en) n_bad++;
        n_en++;
        if (n_en == abort_at) abort = 1'b1;
      end
      if (done) begin n_done++; ab_seen = aborted; end
      if (busy) n_busy++;
      if (cnt_clr || cnt_load) n_strobe++;
      if (int'(cnt_clr) + int'(cnt_load) + int'(cnt_en) > 1) n_bad++;
      if (cmd_ready) break;
      if (c == 999) to = 1'b1;
      step();
    end
    abort = 1'b0;
    step();
  endtask

  int n_en, n_done, n_cyc, n_busy, n_strobe, n_bad;
  logic ab_seen, to;

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0; cmd_op = OP_CLEAR; cmd_arg = '0;
    step(); step();
    n_checks++;
    if ({cnt_clr, cnt_load, cnt_en, busy, done, aborted, mismatch} !== 7'b0 ||
        cnt_load_val !== 8'd0 || run_remaining !== 8'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b/%0d/%0d expected all zero",
        {cnt_clr, cnt_load, cnt_en, busy, done, aborted, mismatch}, cnt_load_val, run_remaining);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_clear_run127();
    do_cmd(OP_CLEAR, 8'd0, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    n_checks++;
    if (n_strobe !== 1 || n_cyc !== 1 || n_done !== 0 || cnt_value !== 8'd0) begin
      n_fail++; $display("FAIL clear: strobes=%0d cyc=%0d done=%0d cnt=%0d expected 1/1/0/0",
        n_strobe, n_cyc, n_done, cnt_value);
    end
    do_cmd(OP_RUN, 8'd127, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    n_checks++;
    if (n_en !== 127 || n_cyc !== 129) begin
      n_fail++; $display("FAIL run127_enables: got en=%0d cyc=%0d expected 127/129", n_en, n_cyc);
    end
    n_checks++;
    if (n_done !== 1 || n_busy !== 128) begin
      n_fail++; $display("FAIL run127_done: got done=%0d busy=%0d expected 1/128", n_done, n_busy);
    end
    n_checks++;
    if (cnt_value !== 8'd127 || mismatch !== 1'b0 || n_bad !== 0 || to) begin
      n_fail++; $display("FAIL run127_result: got cnt=%0d mm=%b bad=%0d to=%b expected 127/0/0/0",
        cnt_value, mismatch, n_bad, to);
    end
  endtask

  task automatic test_load_wrap();
    do_cmd(OP_LOAD, 8'd250, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    n_checks++;
    if (cnt_value !== 8'd250 || n_strobe !== 1 || n_cyc !== 1) begin
      n_fail++; $display("FAIL load250: got cnt=%0d strobes=%0d cyc=%0d expected 250/1/1",
        cnt_value, n_strobe, n_cyc);
    end
    do_cmd(OP_RUN, 8'd10, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    n_checks++;
    if (cnt_value !== 8'd4 || mismatch !== 1'b0 || run_remaining !== 8'd0 || n_en !== 10) begin
      n_fail++; $display("FAIL wrap: got cnt=%0d mm=%b rem=%0d en=%0d expected 4/0/0/10",
        cnt_value, mismatch, run_remaining, n_en);
    end
  endtask

  task automatic test_run_zero();
    do_cmd(OP_RUN, 8'd0, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    n_checks++;
    if (n_en !== 0 || n_done !== 1 || n_busy !== 1 || n_cyc !== 2) begin
      n_fail++; $display("FAIL run0: got en=%0d done=%0d busy=%0d cyc=%0d expected 0/1/1/2",
        n_en, n_done, n_busy, n_cyc);
    end
  endtask

  task automatic test_abort();
    do_cmd(OP_CLEAR, 8'd0, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    do_cmd(OP_RUN, 8'd200, 50, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    n_checks++;
    if (n_en !== 50 || n_done !== 1 || ab_seen !== 1'b1 || n_cyc !== 52) begin
      n_fail++; $display("FAIL abort_run: got en=%0d done=%0d ab=%b cyc=%0d expected 50/1/1/52",
        n_en, n_done, ab_seen, n_cyc);
    end
    n_checks++;
    if (cnt_value !== 8'd50 || aborted !== 1'b1 || run_remaining !== 8'd0) begin
      n_fail++; $display("FAIL abort_state: got cnt=%0d aborted=%b rem=%0d expected 50/1/0",
        cnt_value, aborted, run_remaining);
    end
    // abort while idle has no effect
    abort = 1'b1; step(); step(); abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b1 || cnt_value !== 8'd50) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b done=%b aborted=%b cnt=%0d expected 0/0/1/50",
        busy, done, aborted, cnt_value);
    end
    do_cmd(OP_RSV, 8'd7, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    n_checks++;
    if (aborted !== 1'b0 || cnt_value !== 8'd50 || n_strobe !== 0) begin
      n_fail++; $display("FAIL reserved_op: got aborted=%b cnt=%0d strobes=%0d expected 0/50/0",
        aborted, cnt_value, n_strobe);
    end
  endtask

  task automatic test_stall_mismatch();
    do_cmd(OP_CLEAR, 8'd0, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    stall_at = en_count + 3;
    do_cmd(OP_RUN, 8'd10, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    n_checks++;
    if (mismatch !== 1'b1 || cnt_value !== 8'd9) begin
      n_fail++; $display("FAIL stall_detect: got mm=%b cnt=%0d expected 1/9", mismatch, cnt_value);
    end
    do_cmd(OP_RUN, 8'd5, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    n_checks++;
    if (mismatch !== 1'b1) begin n_fail++; $display("FAIL stall_sticky: got %b expected 1", mismatch); end
    do_cmd(OP_CLEAR, 8'd0, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    step();
    n_checks++;
    if (mismatch !== 1'b0 || cnt_value !== 8'd0) begin
      n_fail++; $display("FAIL stall_clear: got mm=%b cnt=%0d expected 0/0", mismatch, cnt_value);
    end
  endtask

  task automatic test_reset_mid_run();
    do_cmd(OP_CLEAR, 8'd0, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_arg = 8'd100;
    step();
    cmd_valid = 1'b0;
    repeat (30) step();
    // reset must win over a same-edge abort and command
    reset = 1'b1; abort = 1'b1; cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_arg = 8'd77;
    step();
    reset = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
    n_checks++;
    if ({cnt_clr, cnt_load, cnt_en, busy, done, aborted, mismatch} !== 7'b0 ||
        run_remaining !== 8'd0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_run: got %b rem=%0d rdy=%b expected 0000000/0/1",
        {cnt_clr, cnt_load, cnt_en, busy, done, aborted, mismatch}, run_remaining, cmd_ready);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cnt_value !== 8'd31) begin
      n_fail++; $display("FAIL reset_no_done: got done=%b busy=%b cnt=%0d expected 0/0/31",
        done, busy, cnt_value);
    end
    do_cmd(OP_RUN, 8'd5, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    n_checks++;
    if (n_en !== 5 || n_done !== 1 || n_cyc !== 7 || cnt_value !== 8'd36 || mismatch !== 1'b0) begin
      n_fail++; $display("FAIL run_after_reset: got en=%0d done=%0d cyc=%0d cnt=%0d mm=%b expected 5/1/7/36/0",
        n_en, n_done, n_cyc, cnt_value, mismatch);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] model;
    logic [1:0]   op;
    logic [W-1:0] arg;
    int           ab, exp_en, exp_cyc;
    do_cmd(OP_CLEAR, 8'd0, 0, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
    model = 8'd0;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      arg = (op == OP_RUN) ? W'($urandom_range(0, 40)) : W'($urandom);
      ab  = 0;
      if (op == OP_RUN && arg != 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, int'(arg));
      do_cmd(op, arg, ab, n_en, n_done, n_cyc, n_busy, n_strobe, n_bad, ab_seen, to);
      exp_en = 0; exp_cyc = 1;
      case (op)
        OP_CLEAR: model = 8'd0;
        OP_LOAD:  model = arg;
        OP_RUN: begin
          exp_en  = (ab > 0) ? ab : int'(arg);
          exp_cyc = exp_en + 2;
          model   = model + W'(exp_en);
        end
        default: ;
      endcase
      n_checks++;
      if (n_en !== exp_en || n_cyc !== exp_cyc || n_done !== int'(op == OP_RUN) || to) begin
        n_fail++; $display("FAIL rand_seq[%0d] op=%0d arg=%0d: got en=%0d cyc=%0d done=%0d expected %0d/%0d/%0d",
          i, op, arg, n_en, n_cyc, n_done, exp_en, exp_cyc, int'(op == OP_RUN));
      end
      n_checks++;
      if (cnt_value !== model || mismatch !== 1'b0 || aborted !== (ab > 0) || n_bad !== 0) begin
        n_fail++; $display("FAIL rand_state[%0d]: got cnt=%0d mm=%b ab=%b bad=%0d expected %0d/0/%b/0",
          i, cnt_value, mismatch, aborted, n_bad, model, (ab > 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear_run127();
    test_load_wrap();
    test_run_zero();
    test_abort();
    test_stall_mismatch();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
